// File: rtl/gf_mul4_arbiter.sv
// Round-robin arbiter in front of a shared GF(2^4) normal-basis multiplier, with a
// two-stage valid/ready pipeline and one ID-tagged response port.
module gf_mul4_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_q
);

  // GF(2^2) multiply in normal basis [W^2, W]; xs/ys are the precomputed bit sums.
  function automatic logic [1:0] gf2_mul(input logic [1:0] x, input logic [1:0] y,
                                         input logic xs, input logic ys);
    logic e;
    e = xs & ys;
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  function automatic logic [1:0] gf2_scl_n(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] ax, bx, ph, pl, p;
    logic       a_h, a_l, a_xx, b_h, b_l, b_xx;
    ax   = a[3:2] ^ a[1:0];
    bx   = b[3:2] ^ b[1:0];
    a_h  = a[3] ^ a[2];
    a_l  = a[1] ^ a[0];
    a_xx = ax[1] ^ ax[0];
    b_h  = b[3] ^ b[2];
    b_l  = b[1] ^ b[0];
    b_xx = bx[1] ^ bx[0];
    ph   = gf2_mul(a[3:2], b[3:2], a_h, b_h);
    pl   = gf2_mul(a[1:0], b[1:0], a_l, b_l);
    p    = gf2_scl_n(gf2_mul(ax, bx, a_xx, b_xx));
    return {ph ^ p, pl ^ p};
  endfunction

  logic            s1_valid_q;
  logic [IDW-1:0]  s1_id_q;
  logic [3:0]      s1_a_q, s1_b_q;
  logic [3:0]      s1_a_d, s1_b_d;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [3:0]      rsp_prod_q;
  logic [IDW-1:0]  last_q;

  logic            out_en, s1_adv;
  logic            grant_valid;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  cand;
  int unsigned     idx;

  assign out_en = !rsp_valid_q || rsp_ready;
  assign s1_adv = !s1_valid_q || out_en;

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned and a latch is never inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    req_ready   = '0;
    cand        = '0;
    idx         = 0;
    if (s1_adv) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx  = (int'(last_q) + k) % NREQ;
        cand = IDW'(idx);
        if (!grant_valid && req_valid[cand]) begin
          grant_valid = 1'b1;
          grant_id    = cand;
        end
      end
    end
    if (grant_valid) req_ready[grant_id] = 1'b1;
  end

  assign s1_a_d = req_a[{grant_id, 2'b00} +: 4];
  assign s1_b_d = req_b[{grant_id, 2'b00} +: 4];

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values and the S1 -> output handoff happens in the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
      last_q      <= IDW'(NREQ - 1);
    end else begin
      if (s1_adv) begin
        s1_valid_q <= grant_valid;
        if (grant_valid) begin
          s1_id_q <= grant_id;
          s1_a_q  <= s1_a_d;
          s1_b_q  <= s1_b_d;
          last_q  <= grant_id;
        end
      end
      if (out_en) begin
        rsp_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          rsp_id_q   <= s1_id_q;
          rsp_prod_q <= gf4_mul(s1_a_q, s1_b_q);
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_q     = rsp_prod_q;

endmodule

// File: tb/tb_gf_mul4_arbiter.sv
// Directed bench for gf_mul4_arbiter: reset/idle, identity, full product table,
// round-robin order, backpressure and mid-flight reset.
module tb_gf_mul4_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_q;

  int n_checks = 0;
  int n_pass   = 0;

  gf_mul4_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // GF(4) in normal basis [W^2, W] via logs: 11 = 1, 01 = W, 10 = W^2.
  function automatic int gf2_log(input logic [1:0] x);
    case (x)
      2'b11:   return 0;
      2'b01:   return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] gf2_exp(input int e);
    case (e % 3)
      0:       return 2'b11;
      1:       return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] gf2_ref(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'b00 || y == 2'b00) return 2'b00;
    return gf2_exp(gf2_log(x) + gf2_log(y));
  endfunction

  // GF(16) = hY^4 + lY with Y^4+Y = 1 and Y^5 = N = W^2.
  function automatic logic [3:0] gf4_ref(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh, ll, m;
    hh = gf2_ref(a[3:2], b[3:2]);
    ll = gf2_ref(a[1:0], b[1:0]);
    m  = gf2_ref(2'b10, gf2_ref(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
    return {hh ^ m, ll ^ m};
  endfunction

  function automatic logic [31:0] rsp_pack(input logic v, input logic [IDW-1:0] id,
                                          input logic [3:0] q);
    return 32'({v, id, q});
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_q [256];
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    do_reset();

    // Reset then idle
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      check("idle", 32'({rsp_valid, req_ready, rsp_q}), 32'd0);
    end

    // Identity: A * 1 = A, response two cycles after grant
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      req_valid   = 4'b0001;
      req_a[3:0]  = 4'(a);
      req_b[3:0]  = 4'hF;
      #1;
      check("ident_grant", 32'(req_ready), 32'h1);
      @(negedge clk);
      req_valid = '0;
      #1;
      check("ident_lat", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("ident_rsp", rsp_pack(rsp_valid, rsp_id, rsp_q), rsp_pack(1'b1, '0, 4'(a)));
    end

    // Explicit zero, then all 256 pairs streamed one per cycle
    check("ref_zero", 32'(gf4_ref(4'h0, 4'h9)), 32'h0);
    for (int k = 0; k < 256; k++) exp_q[k] = gf4_ref(4'(k >> 4), 4'(k));
    for (int k = 0; k < 258; k++) begin
      @(negedge clk);
      if (k >= 2)
        check("prod", rsp_pack(rsp_valid, rsp_id, rsp_q), rsp_pack(1'b1, '0, exp_q[k-2]));
      if (k < 256) begin
        req_valid  = 4'b0001;
        req_a[3:0] = 4'(k >> 4);
        req_b[3:0] = 4'(k);
      end else begin
        req_valid = '0;
      end
    end
    check("commute", 32'(exp_q[8'h3A] == gf4_ref(4'hA, 4'h3)), 32'd1);

    // Round-robin with all requesters active; A tags requester i as i+1
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[4*i +: 4] = 4'(i + 1);
      req_b[4*i +: 4] = 4'hF;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      if (c < 6) check("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 2)
        check("rr_rsp", rsp_pack(rsp_valid, rsp_id, rsp_q),
              rsp_pack(1'b1, IDW'((c - 2) % 4), 4'((c - 2) % 4 + 1)));
    end
    req_valid = '0;

    // Backpressure: two in flight, then stall, then drain in order
    do_reset();
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    check("bp_grant0", 32'(req_ready), 32'h1);
    @(negedge clk);
    #1;
    check("bp_grant1", 32'(req_ready), 32'h2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("bp_stall_ready", 32'(req_ready), 32'h0);
      check("bp_stall_rsp", rsp_pack(rsp_valid, rsp_id, rsp_q), rsp_pack(1'b1, 2'd0, 4'h1));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp_rel_grant", 32'(req_ready), 32'h4);
    check("bp_rel_rsp0", rsp_pack(rsp_valid, rsp_id, rsp_q), rsp_pack(1'b1, 2'd0, 4'h1));
    @(negedge clk);
    #1;
    check("bp_grant3", 32'(req_ready), 32'h8);
    check("bp_rsp1", rsp_pack(rsp_valid, rsp_id, rsp_q), rsp_pack(1'b1, 2'd1, 4'h2));
    @(negedge clk);
    req_valid = '0;
    check("bp_rsp2", rsp_pack(rsp_valid, rsp_id, rsp_q), rsp_pack(1'b1, 2'd2, 4'h3));
    @(negedge clk);
    check("bp_rsp3", rsp_pack(rsp_valid, rsp_id, rsp_q), rsp_pack(1'b1, 2'd3, 4'h4));
    @(negedge clk);
    check("bp_no_dup", 32'(rsp_valid), 32'd0);

    // Reset with two products in flight
    do_reset();
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'hF;
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check("rst_flush", 32'(rsp_valid), 32'd0);
    rst_n     = 1'b1;
    req_valid = 4'hF;
    #1;
    check("rst_ptr", 32'(req_ready), 32'h1);
    @(negedge clk);
    #1;
    check("rst_empty", 32'(rsp_valid), 32'd0);
    check("rst_grant1", 32'(req_ready), 32'h2);
    @(negedge clk);
    check("rst_rsp0", rsp_pack(rsp_valid, rsp_id, rsp_q), rsp_pack(1'b1, 2'd0, 4'h1));
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gf_mul4_arbiter.md
Name: gf_mul4_arbiter

Overview:
- Shares one combinational GF(2^4)/GF(2^2) shared-factor multiplier (normal basis [alpha^8, alpha^2]) between NREQ requesters.
- Round-robin arbitration, a two-stage valid/ready pipeline and a single response port tagged with the requester ID.
- Sits in the area-reduced serial S-box / key-schedule path, where several sequencers need occasional GF(2^4) products.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must equal ceil(log2(NREQ)), minimum 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_a  input  4*NREQ  operand A, requester i at [4i+3:4i].
- req_b  input  4*NREQ  operand B, same packing.
- req_ready  output  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts result.
- rsp_id  output  IDW  index of the requester that owns rsp_q.
- rsp_q  output  4  product A*B, normal-basis encoding.

Behaviour:
- Reset (rst_n low at edge):
  - s1_valid=0, rsp_valid=0, rsp_id=0, rsp_q=0.
  - RR pointer last=NREQ-1, so requester 0 has first priority.
  - req_ready is combinational and is 0 while rsp_valid and s1_valid are both 1 and rsp_ready=0.
- Pipeline: stage S1 register holds {valid, id, A, B}; output register holds {rsp_valid, rsp_id, rsp_q}.
- Advance conditions:
  - out_en = !rsp_valid | rsp_ready.
  - s1_adv = !s1_valid | out_en.
- Arbitration, combinational, when s1_adv=1:
  - Grant the first i with req_valid[i], searching from last+1 modulo NREQ.
  - req_ready is one-hot at that i, all-zero if none valid or if s1_adv=0.
  - req_ready may depend on req_valid; requesters must hold valid and operands until granted.
- On grant: S1 loads {1, i, req_a[i], req_b[i]}; last<=i. No grant with s1_adv=1: s1_valid<=0.
- Multiply, combinational from S1:
  - Derived factors per operand X: x = X[3:2]^X[1:0], Xh = X[3]^X[2], Xl = X[1]^X[0], xx = x[1]^x[0].
  - Product uses 2-bit shared-factor multiplies ph = Xh-pair, pl = Xl-pair, p = scaled sum product.
  - Q = {ph^p, pl^p}. Must be bit-exact with the team's GF(2^4) shared-factor multiplier; instantiating it is preferred.
- Output register:
  - When out_en: rsp_valid<=s1_valid, and rsp_id/rsp_q load from S1 when s1_valid.
  - When !out_en: hold all output state.
  - rsp_id/rsp_q keep their last value while rsp_valid=0.
- Latency and throughput:
  - Grant at cycle N gives rsp_valid at N+2 with rsp_ready high.
  - Throughput is 1 product/cycle.
  - At most 2 transactions are in flight. Under stall, S1 and the output register each hold one; no loss, no duplication.
- Simultaneous events:
  - The output drains and S1 refills in the same cycle.
  - A new grant happens in the same cycle as S1 moves to the output register.
- Boundaries:
  - The pointer wraps NREQ-1 to 0.
  - A single active requester is granted every cycle.
  - A grant never goes to a requester with req_valid=0.
- Reset mid-operation: in-flight products are discarded, with no rsp_valid the cycle after reset. Requesters whose grant was lost must re-request.
- Field identities (normal basis): 1 = 4'hF, 0 = 4'h0. X*4'hF = X, X*0 = 0, and the product commutes.

Test Plan:
- Reset then idle: rsp_valid=0, req_ready=0, rsp_q=0 for 10 cycles.
- Identity: req0 A=4'h6, B=4'hF with rsp_ready=1 -> rsp_valid at grant+2, rsp_id=0, rsp_q=4'h6. Repeat for all 16 A.
- Zero and commutativity: A=4'h0, B=4'h9 -> 4'h0. All 256 pairs vs. the golden GF(2^4) model; A*B == B*A.
- Round-robin: all 4 requesters valid continuously -> grant order 0,1,2,3,0,1. rsp_id follows the same order two cycles later, one result per cycle.
- Backpressure: rsp_ready=0 with continuous requests -> exactly 2 grants, then req_ready=0 and outputs stable. Releasing rsp_ready yields results in order with no gaps or duplicates.
- Reset mid-flight: rst_n low for 1 cycle with 2 products in flight -> rsp_valid=0 next cycle. The pointer restarts at requester 0.
